// File: rtl/mont_pkg.sv
// mont_pkg -- shared definitions for the Montgomery exponentiation slice.
//   MONT_WIDTH / MONT_EXP_WIDTH : default operand and exponent widths.
//   exp_state_t                 : mont_exp_ctrl FSM state encoding.
// Build option MONT_EXP_SKIP_LZ_EN: when defined, the exponent scanner skips
// leading zero exponent bits before the first squaring. The accumulator
// starts at R mod m, which Montgomery squaring maps to itself, so results
// are identical in both builds; only the operation count and latency change.
package mont_pkg;

  localparam int unsigned MONT_WIDTH     = 512;
  localparam int unsigned MONT_EXP_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SQ_ISSUE,
    ST_SQ_WAIT,
    ST_MUL_ISSUE,
    ST_MUL_WAIT,
    ST_NEXT,
    ST_FIN
  } exp_state_t;

endpackage

// File: rtl/mont_exp_ctrl_scanner.sv
// exp_bit_scanner -- exponent shift register and bit index for mont_exp_ctrl.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load, in_e   : capture a new exponent, index = EXP_WIDTH-1
//   advance      : step to the next lower bit (NEXT state)
//   scan         : controller is in SCAN
//   cur_bit      : exponent bit at the current index
//   last         : current index is 0
//   scan_done    : SCAN may proceed to the first squaring
//   scan_empty   : whole exponent is zero (skip build only)
// Build option MONT_EXP_SKIP_LZ_EN enables leading-zero skipping during SCAN.
module exp_bit_scanner
  import mont_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = MONT_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic                 advance,
  input  logic                 scan,
  output logic                 cur_bit,
  output logic                 last,
  output logic                 scan_done,
  output logic                 scan_empty
);

  localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  // The current bit always sits at the MSB; shifting left walks the index down.
  logic [EXP_WIDTH-1:0] e_sr;
  logic [IDX_W-1:0]     idx;
  logic                 lz_skip;
  logic                 shift;

  assign cur_bit = e_sr[EXP_WIDTH-1];
  assign last    = (idx == '0);

`ifdef MONT_EXP_SKIP_LZ_EN
  assign scan_empty = (e_sr == '0);
  assign lz_skip    = !cur_bit && !last && !scan_empty;
`else
  assign scan_empty = 1'b0;
  assign lz_skip    = 1'b0;
`endif

  assign scan_done = !lz_skip;
  assign shift     = advance || (scan && lz_skip);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_sr <= '0;
      idx  <= '0;
    end else if (load) begin
      e_sr <= in_e;
      idx  <= IDX_W'(EXP_WIDTH - 1);
    end else if (shift) begin
      e_sr <= e_sr << 1;
      idx  <= idx - IDX_W'(1);
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl -- left-to-right square-and-multiply modular exponentiation
// controller; initiator for an external Montgomery multiplier.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   in_x, in_e, in_m    : Montgomery-form base, exponent, odd modulus
//   in_one              : R mod m (initial accumulator)
//   result, done        : final accumulator and its one-cycle strobe
//   busy                : operation in progress, through the done cycle
//   mont_start          : one-cycle multiplier request
//   mont_a/b/m          : multiplier operands
//   mont_result/done    : multiplier response, sampled only in WAIT states
// Build option MONT_EXP_SKIP_LZ_EN: skip leading zero exponent bits in SCAN.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH     = MONT_WIDTH,
  parameter int unsigned EXP_WIDTH = MONT_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_one,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mont_start,
  output logic [WIDTH-1:0]     mont_a,
  output logic [WIDTH-1:0]     mont_b,
  output logic [WIDTH-1:0]     mont_m,
  input  logic [WIDTH-1:0]     mont_result,
  input  logic                 mont_done
);

  exp_state_t state, nxt;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] m_reg;

  logic load_op;
  logic acc_upd;
  logic use_x;
  logic fin;
  logic advance;
  logic scan;
  logic cur_bit;
  logic last;
  logic scan_done;
  logic scan_empty;

  exp_bit_scanner #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .load       (load_op),
    .in_e       (in_e),
    .advance    (advance),
    .scan       (scan),
    .cur_bit    (cur_bit),
    .last       (last),
    .scan_done  (scan_done),
    .scan_empty (scan_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    load_op    = 1'b0;
    acc_upd    = 1'b0;
    use_x      = 1'b0;
    fin        = 1'b0;
    advance    = 1'b0;
    scan       = 1'b0;
    mont_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_op = 1'b1;
          nxt     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan = 1'b1;
        if (scan_empty)     nxt = ST_FIN;
        else if (scan_done) nxt = ST_SQ_ISSUE;
      end
      ST_SQ_ISSUE: begin
        mont_start = 1'b1;
        nxt        = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (mont_done) begin
          acc_upd = 1'b1;
          nxt     = cur_bit ? ST_MUL_ISSUE : ST_NEXT;
        end
      end
      ST_MUL_ISSUE: begin
        mont_start = 1'b1;
        use_x      = 1'b1;
        nxt        = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        use_x = 1'b1;
        if (mont_done) begin
          acc_upd = 1'b1;
          nxt     = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last) begin
          nxt = ST_FIN;
        end else begin
          advance = 1'b1;
          nxt     = ST_SQ_ISSUE;
        end
      end
      ST_FIN: begin
        fin = 1'b1;
        nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // done is registered off FIN so it lines up with the registered result;
  // the FSM is already back in IDLE during that cycle, so busy covers it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      x_reg  <= '0;
      m_reg  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= fin;
      if (load_op) begin
        acc   <= in_one;
        x_reg <= in_x;
        m_reg <= in_m;
      end else if (acc_upd) begin
        acc <= mont_result;
      end
      if (fin) result <= acc;
    end
  end

  // Operands come straight from registers that only move on mont_done,
  // so they stay stable for the whole issue/wait window.
  assign busy   = (state != ST_IDLE) || done;
  assign mont_a = acc;
  assign mont_b = use_x ? x_reg : acc;
  assign mont_m = m_reg;

endmodule
